control_fsm: RTL
================

Name: control_fsm

Overview:
- Multicycle control unit for the datapath. Consumes IReg_out[31:26] and the Branch flag, and drives every datapath control line.
- Moore-style FSM: state is registered; outputs decode combinationally from state plus latched opcode.
- Also provides a retired-instruction counter, a halt indication and an illegal-opcode indication.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)
- HALT_ON_ILLEGAL, 0, 1 = illegal opcode enters HALT; 0 = pulse illegal_op and return to FETCH

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- IReg_out  in  32  instruction register contents; opcode = [31:26]
- Branch  in  1  branch-taken flag from BranchControl
- PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, LUI, SWB  out  1 each  datapath controls
- PCSource  out  2  00 ALU wire, 01 ALU reg, 10 jump, 11 branch
- ALUSrcB  out  2  00 regB, 01 const 1, 10 SE(imm), 11 ZE(imm)
- BranchType  out  3  000 = no branch
- ALUOp  out  4  ALU function
- state  out  4  current state (debug)
- halted  out  1  high while in HALT
- illegal_op  out  1  one-cycle pulse on illegal opcode
- retired  out  RETIRE_W  count of completed instructions

Behaviour:
- Reset (reset==0 at posedge): state<=FETCH, retired<=0. While reset==0, all control outputs are 0 and illegal_op=0.
- Opcode classes:
  - 00xxxx R-ALU: ALUOp=op[3:0]
  - 01xxxx I-ALU: ALUOp=op[3:0]; ZE if ALUOp in {AND,OR,XOR}, else SE
  - 100000 LW, 100001 SW, 100010 LUI
  - 110bbb BR with BranchType=bbb; bbb=000 is illegal
  - 111000 JMP, 111111 HALT
  - all other opcodes are illegal.
- FETCH: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1, BranchType=000. Next state: DECODE.
- DECODE: no writes. Next state by class: R/I/LUI->EXEC, LW->MEM_RD, SW->MEM_WR, BR->BR_EVAL, JMP->JMP, HALT->HALT, illegal->FETCH (or HALT per parameter).
- SWB=1 in every non-FETCH state when class is SW or BR; 0 otherwise.
- EXEC: ALUSrcA=1, ALUSrcB per class (LUI: 11 with ALUOp=PASSB). Next state: ALU_WB.
- ALU_WB: EXEC ALU controls held, RegWrite=1, MemtoReg=0, LUI=1 if LUI. Next state: FETCH; retire.
- MEM_RD: MemRead=1. Next state: MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1. Next state: FETCH; retire.
- MEM_WR: MemWrite=1 for exactly one cycle. Next state: FETCH; retire.
- BR_EVAL: BranchType=op[2:0], PCWrite=0. Next state: BR_RES.
- BR_RES: BranchType held, PCSource=11, PCWrite=Branch. Next state: FETCH; retire.
- JMP: PCSource=10, PCWrite=1. Next state: FETCH; retire.
- HALT: all controls 0, halted=1, stays until reset; not retired.
- Latency in cycles: ALU/LUI 4, LW 4, SW 3, BR 4, JMP 3.
- RegWrite, MemWrite and PCWrite are never asserted in the same cycle.
- retired increments on the posedge that leaves a retiring state.
- illegal_op pulses high in the DECODE cycle of an illegal opcode.
- Reset asserted in any state aborts the instruction: next state FETCH, no write issued in that cycle.

Decomposition:
- Package ctrl_pkg holds: state encoding (4-bit localparams), opcode and class constants, ALUOp codes (ADD=0000, SUB=0001, AND=0100, OR=0101, XOR=0110, PASSB=1111), ALUSrcB and PCSource select codes.
- One sub-module, ctrl_decode: combinational opcode -> {class, aluop, ext_sel, illegal}.

Test Plan:
- Reset low 2 cycles with IReg_out=0 -> state=FETCH, all controls 0, retired=0. Release -> FETCH cycle shows IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-ADD (op 000000) -> states FETCH,DECODE,EXEC,ALU_WB. RegWrite=1 only in cycle 4 with ALUSrcA=1, ALUSrcB=00. retired=1.
- LW (100000) then SW (100001) -> MemRead in cycle 3 and RegWrite+MemtoReg in cycle 4. Then MemWrite in SW cycle 3 with SWB=1 from DECODE on. retired=2 after 7 cycles.
- BR 110001: Branch=1 -> PCWrite=1 and PCSource=11 in BR_RES. Repeat with Branch=0 -> PCWrite=0 throughout BR_RES. retired +1 each.
- Opcode 101111 with HALT_ON_ILLEGAL=0 -> illegal_op pulse in DECODE, return to FETCH, retired unchanged. With HALT_ON_ILLEGAL=1 -> halted=1 held 10 cycles.
- HALT (111111) -> halted=1, no writes. Reset low 1 cycle mid-MEM_WR -> no MemWrite that cycle, state=FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control unit
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_ALU_WB  = 4'd3,
        ST_MEM_RD  = 4'd4,
        ST_MEM_WB  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_BR_EVAL = 4'd7,
        ST_BR_RES  = 4'd8,
        ST_JMP     = 4'd9,
        ST_HALT    = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_LUI, CLS_BR, CLS_JMP, CLS_HALT, CLS_ILL
    } class_t;

    localparam logic [5:0] OP_LW   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100001;
    localparam logic [5:0] OP_LUI  = 6'b100010;
    localparam logic [5:0] OP_JMP  = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_SE  = 2'b10;
    localparam logic [1:0] SRCB_ZE  = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUREG = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_BRANCH = 2'b11;

    localparam logic [2:0] BT_NONE = 3'b000;

    function automatic logic is_retiring(input state_t s);
        return (s == ST_ALU_WB) || (s == ST_MEM_WB) || (s == ST_MEM_WR) ||
               (s == ST_BR_RES) || (s == ST_JMP);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode classifier
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    output class_t     o_class,
    output logic [3:0] o_aluop,
    output logic [1:0] o_ext_sel,
    output logic       o_illegal
);

    always_comb begin
        o_class   = CLS_ILL;
        o_aluop   = ALU_ADD;
        o_ext_sel = SRCB_REG;
        case (i_op[5:4])
            2'b00: begin
                o_class = CLS_R;
                o_aluop = i_op[3:0];
            end
            2'b01: begin
                o_class = CLS_I;
                o_aluop = i_op[3:0];
                // Logical immediates are zero-extended, arithmetic ones sign-extended
                if (i_op[3:0] == ALU_AND || i_op[3:0] == ALU_OR || i_op[3:0] == ALU_XOR)
                    o_ext_sel = SRCB_ZE;
                else
                    o_ext_sel = SRCB_SE;
            end
            2'b10: begin
                if (i_op == OP_LW) begin
                    o_class = CLS_LW;
                end else if (i_op == OP_SW) begin
                    o_class = CLS_SW;
                end else if (i_op == OP_LUI) begin
                    o_class   = CLS_LUI;
                    o_aluop   = ALU_PASSB;
                    o_ext_sel = SRCB_ZE;
                end
            end
            default: begin
                if (i_op[3] == 1'b0) begin
                    if (i_op[2:0] != BT_NONE)
                        o_class = CLS_BR;
                end else if (i_op == OP_JMP) begin
                    o_class = CLS_JMP;
                end else if (i_op == OP_HALT) begin
                    o_class = CLS_HALT;
                end
            end
        endcase
        o_illegal = (o_class == CLS_ILL);
    end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle Moore control unit with retire counter
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int RETIRE_W        = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         IReg_out,
    input  logic                Branch,
    output logic                PCWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                LUI,
    output logic                SWB,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          BranchType,
    output logic [3:0]          ALUOp,
    output logic [3:0]          state,
    output logic                halted,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired
);

    state_t                r_state;
    state_t                w_next;
    logic   [5:0]          r_op;
    logic   [5:0]          w_op;
    class_t                w_class;
    logic   [3:0]          w_aluop;
    logic   [1:0]          w_ext_sel;
    logic                  w_illegal;
    logic                  w_swb_cls;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  w_unused;

    assign w_unused = ^IReg_out[25:0];

    // The IR is only guaranteed valid from DECODE on; later states use the latched copy
    assign w_op = (r_state == ST_DECODE) ? IReg_out[31:26] : r_op;

    ctrl_decode u_decode (
        .i_op      (w_op),
        .o_class   (w_class),
        .o_aluop   (w_aluop),
        .o_ext_sel (w_ext_sel),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_FETCH;
            r_op      <= 6'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE)
                r_op <= IReg_out[31:26];
            if (is_retiring(r_state))
                r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_R, CLS_I, CLS_LUI: w_next = ST_EXEC;
                    CLS_LW:                w_next = ST_MEM_RD;
                    CLS_SW:                w_next = ST_MEM_WR;
                    CLS_BR:                w_next = ST_BR_EVAL;
                    CLS_JMP:               w_next = ST_JMP;
                    CLS_HALT:              w_next = ST_HALT;
                    default:               w_next = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                endcase
            end
            ST_EXEC:    w_next = ST_ALU_WB;
            ST_MEM_RD:  w_next = ST_MEM_WB;
            ST_BR_EVAL: w_next = ST_BR_RES;
            ST_HALT:    w_next = ST_HALT;
            default:    w_next = ST_FETCH;
        endcase
    end

    assign w_swb_cls = (w_class == CLS_SW) || (w_class == CLS_BR);

    // Every control is forced low while reset is held so an aborted cycle issues no write
    always_comb begin
        PCWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        LUI        = 1'b0;
        SWB        = 1'b0;
        PCSource   = PCS_ALU;
        ALUSrcB    = SRCB_REG;
        BranchType = BT_NONE;
        ALUOp      = ALU_ADD;
        halted     = 1'b0;
        illegal_op = 1'b0;
        if (reset) begin
            if (r_state != ST_FETCH && r_state != ST_HALT)
                SWB = w_swb_cls;
            case (r_state)
                ST_FETCH: begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrcB  = SRCB_ONE;
                    ALUOp    = ALU_ADD;
                    PCSource = PCS_ALU;
                end
                ST_DECODE: illegal_op = w_illegal;
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = w_ext_sel;
                    ALUOp   = w_aluop;
                end
                ST_ALU_WB: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = w_ext_sel;
                    ALUOp    = w_aluop;
                    RegWrite = 1'b1;
                    LUI      = (w_class == CLS_LUI);
                end
                ST_MEM_RD: MemRead = 1'b1;
                ST_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                ST_MEM_WR:  MemWrite = 1'b1;
                ST_BR_EVAL: BranchType = w_op[2:0];
                ST_BR_RES: begin
                    BranchType = w_op[2:0];
                    PCSource   = PCS_BRANCH;
                    PCWrite    = Branch;
                end
                ST_JMP: begin
                    PCSource = PCS_JUMP;
                    PCWrite  = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule
